egg_timer: RTL and testbench

//  Kitchen egg timer core: MM:SS register (00:00-59:59) shown as four BCD digits.
//  Set mode (cook_time=1): minutes/seconds buttons step their field up.
//  Run mode (cook_time=0): counts down once per prescaled tick and stops at 00:00.

---
 rtl/egg_timer.sv | 126 ++++++++++++
 tb/tb_egg_timer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/egg_timer.sv
// Egg timer core: BCD MM:SS register, button stepping in set mode,
// prescaled countdown to 00:00 in run mode.
module egg_timer #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       cook_time,
  input  logic       minutes,
  input  logic       seconds,
  output logic       minutes_out,
  output logic       seconds_out,
  output logic [2:0] m_tens,
  output logic [3:0] m_ones,
  output logic [2:0] s_tens,
  output logic [3:0] s_ones
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  // Fields are packed {tens[2:0], ones[3:0]} so 7'h59 reads as "59".
  logic [6:0]    mm_q, mm_d;
  logic [6:0]    ss_q, ss_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          mbtn_q, mbtn_d;
  logic          sbtn_q, sbtn_d;
  logic          mode_q, mode_d;
  logic          mpls_q, mpls_d;
  logic          spls_q, spls_d;

  logic m_press, s_press, t_zero;

  function automatic logic [6:0] bcd_inc(input logic [6:0] v);
    if (v[3:0] == 4'd9) return {v[6:4] + 3'd1, 4'd0};
    return {v[6:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] bcd_dec(input logic [6:0] v);
    if (v[3:0] == 4'd0) return {v[6:4] - 3'd1, 4'd9};
    return {v[6:4], v[3:0] - 4'd1};
  endfunction

  assign m_press = minutes & ~mbtn_q;
  assign s_press = seconds & ~sbtn_q;
  assign t_zero  = (mm_q == 7'h00) && (ss_q == 7'h00);

  always_comb begin
    mm_d    = mm_q;
    ss_d    = ss_q;
    presc_d = presc_q;
    mbtn_d  = mbtn_q;
    sbtn_d  = sbtn_q;
    mode_d  = mode_q;
    mpls_d  = 1'b0;
    spls_d  = 1'b0;
    if (enable) begin
      mbtn_d = minutes;
      sbtn_d = seconds;
      mode_d = cook_time;
      if (cook_time) begin
        presc_d = '0;
        if (s_press) begin
          if (ss_q == 7'h59) begin
            ss_d   = 7'h00;
            spls_d = 1'b1;
          end else begin
            ss_d = bcd_inc(ss_q);
          end
        end
        if (m_press) begin
          if (mm_q == 7'h59) begin
            mm_d   = 7'h00;
            mpls_d = 1'b1;
          end else begin
            mm_d = bcd_inc(mm_q);
          end
        end
      end else if ((cook_time != mode_q) || t_zero) begin
        presc_d = '0;
      end else if (presc_q == PMAX) begin
        presc_d = '0;
        if (ss_q == 7'h00) begin
          ss_d   = 7'h59;
          mm_d   = bcd_dec(mm_q);
          spls_d = 1'b1;
        end else begin
          ss_d = bcd_dec(ss_q);
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mm_q    <= '0;
      ss_q    <= '0;
      presc_q <= '0;
      mbtn_q  <= 1'b0;
      sbtn_q  <= 1'b0;
      mode_q  <= 1'b0;
      mpls_q  <= 1'b0;
      spls_q  <= 1'b0;
    end else begin
      mm_q    <= mm_d;
      ss_q    <= ss_d;
      presc_q <= presc_d;
      mbtn_q  <= mbtn_d;
      sbtn_q  <= sbtn_d;
      mode_q  <= mode_d;
      mpls_q  <= mpls_d;
      spls_q  <= spls_d;
    end
  end

  assign minutes_out = mpls_q;
  assign seconds_out = spls_q;
  assign m_tens      = mm_q[6:4];
  assign m_ones      = mm_q[3:0];
  assign s_tens      = ss_q[6:4];
  assign s_ones      = ss_q[3:0];

endmodule

// File: tb/tb_egg_timer.sv
// Bench for egg_timer: total-seconds reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_egg_timer;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       cook_time = 1'b1;
  logic       minutes = 1'b0;
  logic       seconds = 1'b0;
  logic       minutes_out, seconds_out;
  logic [2:0] m_tens, s_tens;
  logic [3:0] m_ones, s_ones;

  int checks = 0;
  int failures = 0;
  int mo_hi = 0;
  int so_hi = 0;

  egg_timer #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cook_time(cook_time), .minutes(minutes), .seconds(seconds),
    .minutes_out(minutes_out), .seconds_out(seconds_out),
    .m_tens(m_tens), .m_ones(m_ones),
    .s_tens(s_tens), .s_ones(s_ones)
  );

  always #5 clk = ~clk;

  // Model: time kept as total seconds; a tick simply removes one second.
  int t = 0;
  int cnt = 0;
  bit pm = 0, ps = 0, pmode = 0;
  bit e_mo = 0, e_so = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      t = 0; cnt = 0; pm = 0; ps = 0; pmode = 0;
      e_mo = 0; e_so = 0;
    end else begin
      e_mo = 0;
      e_so = 0;
      if (enable) begin
        if (cook_time) begin
          cnt = 0;
          if (seconds && !ps) begin
            if (t % 60 == 59) begin t -= 59; e_so = 1; end
            else t += 1;
          end
          if (minutes && !pm) begin
            if (t / 60 == 59) begin t -= 3540; e_mo = 1; end
            else t += 60;
          end
        end else if (cook_time != pmode || t == 0) begin
          cnt = 0;
        end else begin
          cnt++;
          if (cnt == TD) begin
            cnt = 0;
            if (t % 60 == 0) e_so = 1;
            t--;
          end
        end
        pm = minutes;
        ps = seconds;
        pmode = cook_time;
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] act, exp;
    act = {minutes_out, seconds_out, m_tens, m_ones, s_tens, s_ones};
    exp = {e_mo, e_so, 3'((t / 60) / 10), 4'((t / 60) % 10),
           3'((t % 60) / 10), 4'(t % 10)};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL model t=%0t actual=%h expected=%h", $time, act, exp);
    end
    if (minutes_out === 1'b1) mo_hi++;
    if (seconds_out === 1'b1) so_hi++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int shown();
    return int'(m_tens) * 1000 + int'(m_ones) * 100 +
           int'(s_tens) * 10 + int'(s_ones);
  endfunction

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input bit m, input bit s);
    minutes = m;
    seconds = s;
    cyc(3);
    minutes = 0;
    seconds = 0;
    cyc(2);
  endtask

  initial begin
    int n, m0, s0;
    // 1: reset with buttons toggling
    cyc(1);
    for (int i = 0; i < 4; i++) begin
      minutes = ~minutes;
      seconds = (i % 2 == 0);
      cyc(1);
    end
    chk("reset_digits", shown(), 0);
    chk("reset_pulses", {minutes_out, seconds_out}, 0);
    minutes = 0;
    seconds = 0;
    cyc(1);
    reset = 0;
    cyc(4);
    chk("post_reset_hold", shown(), 0);

    // 2: three seconds presses
    for (int i = 0; i < 3; i++) press(0, 1);
    chk("three_sec", shown(), 3);

    // 3: sixty minutes presses
    m0 = mo_hi;
    for (int i = 0; i < 59; i++) press(1, 0);
    chk("mm_59", shown(), 5903);
    chk("no_early_mo", mo_hi - m0, 0);
    press(1, 0);
    chk("mm_wrap", shown(), 3);
    chk("mo_once", mo_hi - m0, 1);

    // seconds wrap 59->00 without carry, then 01:00
    s0 = so_hi;
    for (int i = 0; i < 57; i++) press(0, 1);
    chk("ss_wrap", shown(), 0);
    chk("so_once", so_hi - s0, 1);
    press(1, 0);
    chk("set_0100", shown(), 100);

    // 4: countdown from 01:00
    cook_time = 0;
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      cyc(1);
      if (seconds_out) n = i;
    end
    chk("first_tick_lat", n, 1 + TD);
    chk("after_1_tick", shown(), 59);
    cyc(59 * TD + 8);
    chk("reach_zero", shown(), 0);
    s0 = so_hi;
    cyc(100);
    chk("hold_zero", shown(), 0);
    chk("no_pulse_done", so_hi - s0, 0);

    // 5: both buttons together
    cook_time = 1;
    cyc(2);
    press(1, 1);
    chk("both_0101", shown(), 101);

    // 6: freeze at 00:05
    for (int i = 0; i < 59; i++) press(1, 0);
    for (int i = 0; i < 4; i++) press(0, 1);
    chk("set_0005", shown(), 5);
    cook_time = 0;
    cyc(2);
    enable = 0;
    minutes = 1;
    seconds = 1;
    cyc(20 * TD);
    chk("frozen", shown(), 5);
    minutes = 0;
    seconds = 0;
    enable = 1;
    n = 0;
    for (int i = 1; i <= 10 && n == 0; i++) begin
      cyc(1);
      if (s_ones == 4'd4) n = i;
    end
    chk("resume_lat", n, 3);
    cyc(3);
    @(posedge clk);
    #3;
    reset = 1;
    #1;
    chk("async_reset", shown(), 0);
    cyc(2);
    reset = 0;
    cyc(5);
    chk("after_reset_run", shown(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
